byte_match_unit: RTL

- Multi-cycle execute-stage engine for the `match` operation.
- Takes the same operand pair the EX stage presents to the ALU:
  - `src1[7:0]` is the 8-bit pattern.
  - `src2` is the 32-bit haystack.
- Scans `src2` from bit 0 upward for the lowest bit offset where an 8-bit window equals the pattern.
- Its result is muxed downstream of `alu_result` in EX. It holds the pipeline via `stallreq` while scanning.

---
 rtl/byte_match_unit_pkg.sv | 14 +
 rtl/byte_match_unit_cmp.sv | 38 +++
 rtl/byte_match_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/byte_match_unit_pkg.sv
// rtl/byte_match_unit_pkg.sv - shared constants and state encoding for the match engine
package byte_match_unit_pkg;

  localparam logic [6:0]  OPC_MATCH = 7'b000_1011;
  localparam logic [31:0] NOMATCH   = 32'hFFFF_FFFF;
  localparam int          STALL_W   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_match_unit_cmp.sv
// rtl/byte_match_unit_cmp.sv - compares LANES window positions starting at base
module match_lane_cmp #(
  parameter int DATA_W = 32,
  parameter int WIN_W  = 8,
  parameter int LANES  = 1,
  parameter int PW     = 6,
  parameter int IDX_W  = 1
) (
  input  logic [DATA_W-1:0] hay,
  input  logic [WIN_W-1:0]  pat,
  input  logic [PW-1:0]     base,
  output logic [LANES-1:0]  hit_vec,
  output logic [IDX_W-1:0]  hit_idx,
  output logic              any_hit
);

  localparam logic [PW-1:0]     MAX_POS  = PW'(DATA_W - WIN_W);
  localparam logic [DATA_W-1:0] WIN_MASK = {{(DATA_W-WIN_W){1'b0}}, {WIN_W{1'b1}}};

  logic [PW-1:0] pos;

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    pos     = '0;
    // Positions past the last full window are masked so they can never hit.
    for (int i = 0; i < LANES; i++) begin
      pos        = base + PW'(i);
      hit_vec[i] = (pos <= MAX_POS) && (((hay >> pos) & WIN_MASK) == DATA_W'(pat));
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  assign any_hit = |hit_vec;

endmodule

// File: rtl/byte_match_unit.sv
// rtl/byte_match_unit.sv - multi-cycle byte pattern search for the EX stage
module byte_match_unit
  import byte_match_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WIN_W  = 8,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [31:0]       src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              stallreq_o,
  output logic              done_o,
  output logic [31:0]       result_o
);

  localparam int PW    = $clog2(DATA_W) + 1;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PW-1:0] MAX_POS = PW'(DATA_W - WIN_W);

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  pat_q;
  logic [DATA_W-1:0] hay_q;
  logic [PW-1:0]     base_q;
  logic [31:0]       result_q, res_d;
  logic              accept, load_res;
  logic [PW-1:0]     last_pos, hit_pos;
  logic [LANES-1:0]  hit_vec;
  logic [IDX_W-1:0]  hit_idx;
  logic              any_hit;
  logic              unused_src1;

  assign unused_src1 = ^src1_i[31:WIN_W];

  match_lane_cmp #(
    .DATA_W(DATA_W), .WIN_W(WIN_W), .LANES(LANES), .PW(PW), .IDX_W(IDX_W)
  ) u_cmp (
    .hay(hay_q), .pat(pat_q), .base(base_q),
    .hit_vec(hit_vec), .hit_idx(hit_idx), .any_hit(any_hit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    accept     = 1'b0;
    load_res   = 1'b0;
    res_d      = result_q;
    last_pos   = base_q + PW'(LANES - 1);
    hit_pos    = base_q + PW'(hit_idx);
    case (state_q)
      ST_IDLE: begin
        stallreq_o = start_i & ~flush_i;
        if (start_i && !flush_i) begin
          accept  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        stallreq_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (any_hit) begin
          load_res = 1'b1;
          res_d    = 32'(hit_pos);
          state_d  = ST_DONE;
        end else if (last_pos >= MAX_POS) begin
          load_res = 1'b1;
          res_d    = NOMATCH;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are captured only on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat_q    <= '0;
      hay_q    <= '0;
      base_q   <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        pat_q  <= src1_i[WIN_W-1:0];
        hay_q  <= src2_i;
        base_q <= '0;
      end else if (state_q == ST_SCAN) begin
        base_q <= base_q + PW'(LANES);
      end
      if (load_res) result_q <= res_d;
    end
  end

  assign done_o   = (state_q == ST_DONE) & ~flush_i;
  assign result_o = result_q;

endmodule
